// File: rtl/sram_ctl.sv
// Cycle-timed controller for two 16-bit async SRAMs: setup, strobe, hold, then ack.
// Define SRAM_POSTWR_EN for a single-entry posted-write buffer (write acked right after capture).
module sram_ctl #(
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned STROBE_CY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data_in,
    output logic [15:0]       data_out,
    input  logic              rd,
    input  logic              wr,
    input  logic              byte_op,
    input  logic              wr_inhibit,
    output logic              ack,
    output logic              busy,
    output logic [17:0]       ram_a,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    inout  wire  [15:0]       ram1_io,
    output logic              ram1_ce_n,
    output logic              ram1_ub_n,
    output logic              ram1_lb_n,
    inout  wire  [15:0]       ram2_io,
    output logic              ram2_ce_n,
    output logic              ram2_ub_n,
    output logic              ram2_lb_n
);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StDone} state_e;

    // Async assert, sync deassert of the internal reset.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d, is_byte_q, is_byte_d, inhibit_q, inhibit_d;
    logic        lane_q, lane_d, chip_q, chip_d;
    logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d, data_out_q, data_out_d;
    logic [17:0] ram_a_q, ram_a_d;
    logic        ack_q, ack_d, busy_q, busy_d;
    logic        oe_n_q, oe_n_d, we_n_q, we_n_d, drive_q, drive_d;
    logic        ce1_n_q, ce1_n_d, ce2_n_q, ce2_n_d, ub_n_q, ub_n_d, lb_n_q, lb_n_d;
    logic        active, strobe;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_wr_d    = is_wr_q;
        is_byte_d  = is_byte_q;
        inhibit_d  = inhibit_q;
        lane_d     = lane_q;
        chip_d     = chip_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        data_out_d = data_out_q;
        ram_a_d    = ram_a_q;
        ack_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rd || wr) begin
                    state_d   = StSetup;
                    is_wr_d   = wr;
                    is_byte_d = byte_op;
                    inhibit_d = wr_inhibit;
                    lane_d    = addr[0];
                    chip_d    = addr[ADDR_W-1];
                    ram_a_d   = 18'({1'b0, addr[ADDR_W-2:1]});
                    wdata_d   = byte_op ? {2{data_in[7:0]}} : data_in;
`ifdef SRAM_POSTWR_EN
                    ack_d     = wr;
`endif
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = 4'(STROBE_CY - 1);
            end
            StStrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StHold;
                    rdata_d = chip_q ? ram2_io : ram1_io;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
`ifdef SRAM_POSTWR_EN
                // Posted writes were acked at capture; drain straight back to idle.
                state_d = is_wr_q ? StIdle : StDone;
`else
                state_d = StDone;
`endif
                if (state_d == StDone) begin
                    ack_d = 1'b1;
                    if (!is_wr_q) begin
                        data_out_d = is_byte_q ?
                                     {8'h00, (lane_q ? rdata_q[15:8] : rdata_q[7:0])} : rdata_q;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        active  = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
        strobe  = (state_d == StStrobe);
        busy_d  = (state_d != StIdle);
        ce1_n_d = !(active && !chip_d);
        ce2_n_d = !(active && chip_d);
        ub_n_d  = !(active && (!is_byte_d || lane_d));
        lb_n_d  = !(active && (!is_byte_d || !lane_d));
        oe_n_d  = !(strobe && !is_wr_d);
        we_n_d  = !(strobe && is_wr_d && !inhibit_d);
        drive_d = active && is_wr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            is_wr_q    <= 1'b0;
            is_byte_q  <= 1'b0;
            inhibit_q  <= 1'b0;
            lane_q     <= 1'b0;
            chip_q     <= 1'b0;
            wdata_q    <= 16'h0000;
            rdata_q    <= 16'h0000;
            data_out_q <= 16'h0000;
            ram_a_q    <= 18'h00000;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            drive_q    <= 1'b0;
            ce1_n_q    <= 1'b1;
            ce2_n_q    <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_wr_q    <= is_wr_d;
            is_byte_q  <= is_byte_d;
            inhibit_q  <= inhibit_d;
            lane_q     <= lane_d;
            chip_q     <= chip_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            data_out_q <= data_out_d;
            ram_a_q    <= ram_a_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            drive_q    <= drive_d;
            ce1_n_q    <= ce1_n_d;
            ce2_n_q    <= ce2_n_d;
            ub_n_q     <= ub_n_d;
            lb_n_q     <= lb_n_d;
        end
    end

    assign data_out  = data_out_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign ram_a     = ram_a_q;
    assign ram_oe_n  = oe_n_q;
    assign ram_we_n  = we_n_q;
    assign ram1_ce_n = ce1_n_q;
    assign ram2_ce_n = ce2_n_q;
    // Lane enables only reach the selected chip.
    assign ram1_ub_n = ub_n_q | chip_q;
    assign ram1_lb_n = lb_n_q | chip_q;
    assign ram2_ub_n = ub_n_q | !chip_q;
    assign ram2_lb_n = lb_n_q | !chip_q;
    assign ram1_io   = (drive_q && !chip_q) ? wdata_q : 16'hzzzz;
    assign ram2_io   = (drive_q && chip_q) ? wdata_q : 16'hzzzz;

endmodule
